// File: rtl/instr_load_pkg.sv
// Shared types and constants for the instruction memory loader.
package instr_load_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FLUSH,
        DONE,
        ERR
    } state_t;

    localparam int BYTES_PER_WORD  = 4;
    // The memory indexes words as addr/4.
    localparam int WORD_ADDR_SHIFT = 2;

    // Byte address of a given word index.
    function automatic logic [31:0] word_byte_addr(input logic [31:0] idx);
        return idx << WORD_ADDR_SHIFT;
    endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the loader.
interface instr_mem_loader_if;
    logic [7:0]  byte_i;
    logic        byte_valid_i;
    logic        byte_ready_o;
    logic        wr_en_o;
    logic [31:0] wr_addr_o;
    logic [31:0] wr_data_o;

    // Host / memory side.
    modport master (
        output byte_i, byte_valid_i,
        input  byte_ready_o, wr_en_o, wr_addr_o, wr_data_o
    );

    // Loader side.
    modport slave (
        input  byte_i, byte_valid_i,
        output byte_ready_o, wr_en_o, wr_addr_o, wr_data_o
    );
endinterface

// File: rtl/instr_mem_loader_word_assembler.sv
// Packs accepted bytes big-endian into 32-bit words.
module word_assembler
    import instr_load_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic [7:0]  byte_i,
    input  logic        fire_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    // Only the first three bytes are stored; the fourth is taken straight
    // from the input so the word is complete in the handshake cycle.
    logic [23:0] shreg;
    logic [1:0]  cnt;

    // Shift register and byte count, cleared at the start of every load.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (clr_i) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (fire_i) begin
            shreg <= {shreg[15:0], byte_i};
            cnt   <= cnt + 2'd1;
        end
    end

    // Word completes on the handshake of its last byte.
    always_comb begin
        word_valid_o = fire_i && (cnt == 2'(BYTES_PER_WORD - 1));
        word_o       = {shreg, byte_i};
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a program image from a byte stream into instruction memory and
// holds the CPU in reset until the image is complete.
module instr_mem_loader
    import instr_load_pkg::*;
#(
    parameter int MEM_DEPTH = 32,
    parameter int LEN_W     = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    instr_mem_loader_if.slave bus,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic             cpu_hold_o
);

    state_t           state, state_nxt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] word_idx;
    logic             fire;
    logic             load_go;
    logic             word_valid;
    logic [31:0]      word;
    logic             wr_en_q;
    logic [31:0]      wr_addr_q;
    logic [31:0]      wr_data_q;

    word_assembler u_asm (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clr_i        (load_go),
        .byte_i       (bus.byte_i),
        .fire_i       (fire),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and state-decoded outputs; byte_ready drops the cycle after
    // the last word completes, so nothing past 4*len is accepted.
    always_comb begin
        state_nxt        = state;
        load_go          = 1'b0;
        bus.byte_ready_o = (state == LOAD);
        busy_o           = (state == LOAD) || (state == FLUSH);
        done_o           = (state == DONE);
        err_o            = (state == ERR);
        cpu_hold_o       = (state != DONE);
        fire             = bus.byte_valid_i && bus.byte_ready_o;
        case (state)
            IDLE, DONE, ERR: begin
                if (start_i) begin
                    if (len_i == '0)
                        state_nxt = DONE;
                    else if (int'(len_i) > MEM_DEPTH)
                        state_nxt = ERR;
                    else begin
                        state_nxt = LOAD;
                        load_go   = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (word_valid && (word_idx == len_q - LEN_W'(1)))
                    state_nxt = FLUSH;
            end
            FLUSH:   state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Load length and word index; the index advances as each word is issued.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            len_q    <= '0;
            word_idx <= '0;
        end else if (load_go) begin
            len_q    <= len_i;
            word_idx <= '0;
        end else if (word_valid) begin
            word_idx <= word_idx + LEN_W'(1);
        end
    end

    // Write registers: one-cycle strobe, address/data held between writes.
    // Data is copied out so the next word can assemble during the write.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= word_valid;
            if (word_valid) begin
                wr_addr_q <= word_byte_addr(32'(word_idx));
                wr_data_q <= word;
            end
        end
    end

    // Drive the write bus from the registers.
    always_comb begin
        bus.wr_en_o   = wr_en_q;
        bus.wr_addr_o = wr_addr_q;
        bus.wr_data_o = wr_data_q;
    end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
Writer side of the instruction memory. Accepts a byte stream from a host link over a valid/ready handshake and packs it into 32-bit instruction words. Issues one write per word into the writable instruction memory array at word-aligned byte addresses 0, 4, 8, and so on. Holds the CPU in reset until the program image is fully written.

Parameters:
MEM_DEPTH, 32, number of 32-bit words in the instruction memory.
LEN_W, 6, width of len_i; equals clog2(MEM_DEPTH)+1 so the value MEM_DEPTH is representable.

Ports:
clk_i  input  1  clock; all state updates on rising edge.
rst_i  input  1  asynchronous, active-low reset.
start_i  input  1  one-cycle pulse that begins a load; only acted on in IDLE, DONE or ERR.
len_i  input  LEN_W  number of words to load; sampled when start_i is acted on.
byte_i  input  8  stream byte.
byte_valid_i  input  1  byte_i is valid.
byte_ready_o  output  1  loader accepts a byte; a transfer occurs when byte_valid_i and byte_ready_o are both 1.
wr_en_o  output  1  one-cycle write strobe to the instruction memory.
wr_addr_o  output  32  byte address of the write; always a multiple of 4.
wr_data_o  output  32  instruction word being written.
busy_o  output  1  load in progress (LOAD or FLUSH).
done_o  output  1  level; last load completed successfully.
err_o  output  1  level; last start was rejected because len_i > MEM_DEPTH.
cpu_hold_o  output  1  1 keeps the CPU in reset.

Behaviour:
- States: IDLE, LOAD, FLUSH, DONE, ERR.
- Reset (rst_i=0, asynchronous): state=IDLE; byte_ready_o=0, wr_en_o=0, wr_addr_o=0, wr_data_o=0, busy_o=0, done_o=0, err_o=0, cpu_hold_o=1. Internal byte count, word index and shift register are cleared. Memory contents are not cleared, so a reset mid-load leaves a partial image in memory.
- IDLE/DONE/ERR on start_i:
  - len_i==0: go to DONE.
  - len_i>MEM_DEPTH: go to ERR.
  - Otherwise go to LOAD: latch len, byte_cnt=0, word_idx=0.
  - Entering LOAD or ERR sets cpu_hold_o=1, done_o=0 and, for LOAD, err_o=0.
- LOAD:
  - byte_ready_o=1 and busy_o=1.
  - Big-endian packing: the first byte of each word lands in [31:24] and the fourth in [7:0].
  - On each accepted byte, byte_cnt increments modulo 4.
  - The cycle after the 4th byte of a word is accepted: wr_en_o=1 for exactly one cycle, wr_addr_o=word_idx*4, wr_data_o=assembled word, and word_idx increments. Write latency is 1 cycle after the completing handshake.
  - Bytes keep being accepted during the write cycle, giving full throughput of 1 byte/cycle. The assembled word is copied into the wr_data_o register, so the next word's assembly does not corrupt it.
  - A handshake completing word len-1 moves the state to FLUSH. byte_ready_o goes 0 from the next cycle, so no byte beyond 4*len is ever accepted.
  - byte_valid_i low simply stalls; there is no timeout.
  - start_i is ignored in LOAD and FLUSH.
- FLUSH: issues the final write (wr_en_o=1), then moves to DONE.
- DONE: done_o=1, busy_o=0, cpu_hold_o=0; the CPU runs.
- ERR: err_o=1, cpu_hold_o=1, byte_ready_o=0; no writes are issued.
- wr_en_o is 0 in every cycle other than the write cycles above. wr_addr_o and wr_data_o hold their last values between writes.
- Simultaneous start_i and byte_valid_i in IDLE: no byte is accepted in that cycle, because byte_ready_o is 0.
- word_idx never exceeds len-1 < MEM_DEPTH, so there is no address wrap.

Decomposition:
- Shared package instr_load_pkg holds:
  - the state enum (IDLE, LOAD, FLUSH, DONE, ERR);
  - BYTES_PER_WORD=4;
  - WORD_ADDR_SHIFT=2, matching the memory's addr/4 word indexing.
- One sub-module, word_assembler: shifts in bytes, keeps a 2-bit count, and emits word_valid together with the packed word. The top level keeps the FSM, word index and write registers.

Test Plan:
- Reset values: hold rst_i=0 for 3 cycles, then release -> byte_ready_o=0, wr_en_o=0, busy_o=0, done_o=0, err_o=0, cpu_hold_o=1.
- Single-word load: start_i with len_i=1, then bytes 8'h20, 8'h01, 8'h00, 8'h05 back-to-back -> one wr_en_o pulse 1 cycle after the 4th byte with wr_addr_o=0 and wr_data_o=32'h20010005. The next cycle done_o=1 and cpu_hold_o=0. The byte count was exactly 4.
- Full-depth load with random byte_valid_i gaps: len_i=32, word k = 32'hA5000000+k -> 32 writes at addresses 0, 4, …, 124 with matching data. byte_ready_o falls after byte 128, and a 129th offered byte is never accepted.
- Overlength: start_i with len_i=33 -> err_o=1, no wr_en_o, cpu_hold_o=1. A following start_i with len_i=2 clears err_o and loads normally.
- Zero length: len_i=0 -> DONE in 1 cycle, no writes, cpu_hold_o=0.
- Reset mid-load: rst_i=0 after 6 bytes of a len_i=3 load -> immediate return to reset values, exactly one write seen (addr 0). A subsequent len_i=3 load completes correctly.
